// File: rtl/dm_lane_ctrl.sv
// dm_lane_ctrl: one DM/DQ lane. Delays parallel write data by TRI_LEAD+1 cycles,
// opens the shared tristate window around every word, and moves staged output
// delay values to the delay lines only while the lane is not transmitting.
module dm_lane_ctrl #(
    parameter int   WIDTH     = 2,
    parameter int   TRI_LEAD  = 1,
    parameter int   TRI_TRAIL = 1,
    parameter logic IDLE_VAL  = 1'b0,
    localparam int  AW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [4*WIDTH-1:0]   din,
    input  logic                 dly_we,
    input  logic [AW-1:0]        dly_addr,
    input  logic [7:0]           dly_data,
    input  logic                 dly_apply,
    output logic [4*WIDTH-1:0]   dout,
    output logic [3:0]           tout,
    output logic [8*WIDTH-1:0]   dly_out,
    output logic                 set_odelay,
    output logic                 ld_odelay,
    output logic                 dly_busy
);

    localparam int LAT = TRI_LEAD + 1;
    localparam int WIN = LAT + TRI_TRAIL;
    localparam logic [4*WIDTH-1:0] IDLE_WORD = {(4*WIDTH){IDLE_VAL}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_SET,
        S_WAIT,
        S_LD
    } state_t;

    state_t               state_q, state_d;
    logic [4*WIDTH-1:0]   pipe_q [LAT];
    logic [2:0]           win_q, win_d;
    logic [7:0]           shadow_q [WIDTH];
    logic [7:0]           shadow_d [WIDTH];
    logic [8*WIDTH-1:0]   dly_out_q, dly_out_d;
    logic                 lane_active;

    // The window counter holds how many tristate-open cycles remain, counting the
    // current one; each new word reloads the full window so overlaps merge.
    always_comb begin
        win_d = win_q;
        if (wr_en) begin
            win_d = 3'(WIN);
        end else if (win_q != 3'd0) begin
            win_d = win_q - 3'd1;
        end
    end

    assign lane_active = wr_en || (win_q != 3'd0);

    // Data delay line and window counter; idle slots carry the idle pattern.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= IDLE_WORD;
            end
            win_q <= 3'd0;
        end else begin
            pipe_q[0] <= wr_en ? din : IDLE_WORD;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            win_q <= win_d;
        end
    end

    // Shadow next-state: a write to an index past the lane width matches no entry.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (dly_we && (int'(dly_addr) == i)) begin
                shadow_d[i] = dly_data;
            end
        end
    end

    // Apply sequencer next state: waits in PEND until the lane goes quiet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dly_apply) state_d = S_PEND;
            S_PEND:  if (!lane_active) state_d = S_SET;
            S_SET:   state_d = S_WAIT;
            S_WAIT:  state_d = S_LD;
            S_LD:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Active delays are copied from the shadow (including a same-cycle write)
    // only on the edge that enters SET.
    always_comb begin
        dly_out_d = dly_out_q;
        if ((state_q == S_PEND) && (state_d == S_SET)) begin
            for (int i = 0; i < WIDTH; i++) begin
                dly_out_d[8*i +: 8] = shadow_d[i];
            end
        end
    end

    // Sequencer state, shadow bank and active delay registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            dly_out_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            dly_out_q <= dly_out_d;
            for (int i = 0; i < WIDTH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign dout       = pipe_q[LAT-1];
    assign tout       = (win_q != 3'd0) ? 4'h0 : 4'hF;
    assign dly_out    = dly_out_q;
    assign set_odelay = (state_q == S_SET);
    assign ld_odelay  = (state_q == S_LD);
    assign dly_busy   = (state_q != S_IDLE);

endmodule
